// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with zero-latency hits.
// Misses stall in FETCH until the memory controller drops iwait, then fill the frame.
module icache #(
   parameter int FRAMES = 16
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic [31:0] imemload,
   output logic        ihit,
   input  logic        iflush,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic [31:0] iload,
   input  logic        iwait,
   output logic        dbg_state
);

   localparam int IW = $clog2(FRAMES);
   localparam int TW = 30 - IW;

   typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

   state_t            state, state_n;
   logic [FRAMES-1:0] valid;
   logic [TW-1:0]     tags [FRAMES];
   logic [31:0]       data [FRAMES];
   logic [31:0]       miss_addr;
   logic [IW-1:0]     idx, miss_idx;
   logic [TW-1:0]     tag, miss_tag;
   logic              lookup_hit;
   logic              latch;
   logic              fill;

   assign idx        = imemaddr[IW+1:2];
   assign tag        = imemaddr[31:IW+2];
   assign miss_idx   = miss_addr[IW+1:2];
   assign miss_tag   = miss_addr[31:IW+2];
   assign lookup_hit = valid[idx] && (tags[idx] == tag) && !iflush;
   assign dbg_state  = state;

   // Memory handshake: iREN is held with a stable iaddr for the whole of FETCH;
   // the access completes in the cycle where iwait is low, and iload is taken then.
   always_comb begin
      state_n  = state;
      ihit     = 1'b0;
      imemload = 32'h0;
      iREN     = 1'b0;
      iaddr    = 32'h0;
      latch    = 1'b0;
      fill     = 1'b0;
      case (state)
         IDLE: begin
            if (imemREN) begin
               if (lookup_hit) begin
                  ihit     = 1'b1;
                  imemload = data[idx];
               end else begin
                  latch   = 1'b1;
                  state_n = FETCH;
               end
            end
         end
         FETCH: begin
            iREN  = 1'b1;
            iaddr = miss_addr;
            if (iflush) begin
               state_n = IDLE;
            end else if (!iwait) begin
               fill    = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge nRST) begin
      if (nRST) begin
         state     <= IDLE;
         valid     <= '0;
         miss_addr <= 32'h0;
      end else begin
         state <= state_n;
         if (latch) miss_addr <= {imemaddr[31:2], 2'b00};
         if (iflush) valid <= '0;
         else if (fill) valid[miss_idx] <= 1'b1;
      end
   end

   // Tag/data arrays need no reset: valid bits gate every use.
   always_ff @(posedge CLK) begin
      if (fill) begin
         tags[miss_idx] <= miss_tag;
         data[miss_idx] <= iload;
      end
   end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, hit, conflict, fetch address change,
// flush, flush-abort and asynchronous reset during a fetch.
module tb_icache;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic [31:0] imemload;
   logic        ihit;
   logic        iflush;
   logic        iREN;
   logic [31:0] iaddr;
   logic [31:0] iload;
   logic        iwait;
   logic        dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_q[$];

   icache #(.FRAMES(16)) dut (
      .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
      .imemload(imemload), .ihit(ihit), .iflush(iflush), .iREN(iREN),
      .iaddr(iaddr), .iload(iload), .iwait(iwait), .dbg_state(dbg_state)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Miss on addr, nwait busy cycles, then fill with dat; ends in the hit cycle.
   task automatic do_miss(input logic [31:0] addr, input logic [31:0] dat, input int nwait);
      logic [31:0] exp_addr;
      exp_addr = exp_q.pop_front();
      imemREN  = 1'b1;
      imemaddr = addr;
      iwait    = 1'b1;
      settle();
      chk("miss_ihit", {31'b0, ihit}, 32'h0);
      chk("miss_iren_idle", {31'b0, iREN}, 32'h0);
      tick();
      for (int i = 0; i < nwait; i++) begin
         settle();
         chk("fetch_iren", {31'b0, iREN}, 32'h1);
         chk("fetch_iaddr", iaddr, exp_addr);
         tick();
      end
      iwait = 1'b0;
      iload = dat;
      settle();
      chk("done_iren", {31'b0, iREN}, 32'h1);
      chk("done_iaddr", iaddr, exp_addr);
      chk("done_ihit", {31'b0, ihit}, 32'h0);
      tick();
      iwait = 1'b1;
      settle();
      chk("refill_ihit", {31'b0, ihit}, 32'h1);
      chk("refill_load", imemload, dat);
      chk("refill_iren", {31'b0, iREN}, 32'h0);
   endtask

   initial begin
      nRST = 1'b1; imemREN = 1'b1; imemaddr = 32'h40; iflush = 1'b0;
      iload = 32'h0; iwait = 1'b1;
      tick(); tick();
      chk("rst_ihit", {31'b0, ihit}, 32'h0);
      chk("rst_load", imemload, 32'h0);
      chk("rst_iren", {31'b0, iREN}, 32'h0);
      chk("rst_iaddr", iaddr, 32'h0);
      chk("rst_state", {31'b0, dbg_state}, 32'h0);
      imemREN = 1'b0;
      nRST    = 1'b0;
      tick();

      // Cold miss with 3 busy cycles, then hit on repeat
      exp_q.push_back(32'h40);
      do_miss(32'h40, 32'h8C010004, 3);
      tick();
      chk("hit_ihit", {31'b0, ihit}, 32'h1);
      chk("hit_load", imemload, 32'h8C010004);
      chk("hit_iren", {31'b0, iREN}, 32'h0);
      imemREN = 1'b0;
      settle();
      chk("noren_ihit", {31'b0, ihit}, 32'h0);
      chk("noren_load", imemload, 32'h0);
      tick();

      // Conflict on index 0
      exp_q.push_back(32'h440);
      do_miss(32'h440, 32'h11111111, 1);
      tick();
      exp_q.push_back(32'h40);
      do_miss(32'h40, 32'h8C010004, 0);
      tick();

      // Address change during fetch
      imemREN = 1'b1; imemaddr = 32'h80; iwait = 1'b1;
      settle();
      chk("chg_miss", {31'b0, ihit}, 32'h0);
      tick();
      imemaddr = 32'h84;
      settle();
      chk("chg_iaddr1", iaddr, 32'h80);
      chk("chg_state", {31'b0, dbg_state}, 32'h1);
      tick();
      iwait = 1'b0; iload = 32'hAAAA0080;
      settle();
      chk("chg_iaddr2", iaddr, 32'h80);
      tick();
      iwait = 1'b1;
      settle();
      chk("chg_84_miss", {31'b0, ihit}, 32'h0);
      tick();
      settle();
      chk("chg_84_iaddr", iaddr, 32'h84);
      iwait = 1'b0; iload = 32'hBBBB0084;
      tick();
      iwait = 1'b1;
      settle();
      chk("chg_84_hit", {31'b0, ihit}, 32'h1);
      chk("chg_84_load", imemload, 32'hBBBB0084);
      imemaddr = 32'h80;
      settle();
      chk("chg_80_hit", {31'b0, ihit}, 32'h1);
      chk("chg_80_load", imemload, 32'hAAAA0080);
      tick();
      exp_q.push_back(32'h40);
      do_miss(32'h40, 32'h8C010004, 0);

      // Flush in IDLE forces ihit low and invalidates everything
      iflush = 1'b1;
      settle();
      chk("flush_ihit", {31'b0, ihit}, 32'h0);
      imemREN = 1'b0;
      tick();
      iflush = 1'b0;
      exp_q.push_back(32'h40);
      do_miss(32'h40, 32'h8C010004, 1);
      iflush = 1'b1; imemREN = 1'b0;
      tick();
      iflush = 1'b0;

      // Flush aborts a fetch even with iwait low
      imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b1;
      tick();
      iwait = 1'b0; iload = 32'hDEADBEEF; iflush = 1'b1;
      settle();
      chk("abort_iren", {31'b0, iREN}, 32'h1);
      tick();
      iflush = 1'b0; iwait = 1'b1;
      settle();
      chk("abort_state", {31'b0, dbg_state}, 32'h0);
      chk("abort_ihit", {31'b0, ihit}, 32'h0);
      chk("abort_iren_off", {31'b0, iREN}, 32'h0);
      imemREN = 1'b0;
      tick();
      exp_q.push_back(32'h40);
      do_miss(32'h40, 32'h8C010004, 0);

      // Async reset mid-fetch
      imemaddr = 32'h100;
      tick();
      settle();
      chk("ar_iren_before", {31'b0, iREN}, 32'h1);
      chk("ar_iaddr_before", iaddr, 32'h100);
      nRST = 1'b1;
      #1;
      chk("ar_iren", {31'b0, iREN}, 32'h0);
      chk("ar_iaddr", iaddr, 32'h0);
      chk("ar_state", {31'b0, dbg_state}, 32'h0);
      iwait = 1'b0; iload = 32'h12345678;
      tick();
      nRST = 1'b0; iwait = 1'b1; imemaddr = 32'h40;
      settle();
      chk("ar_40_miss", {31'b0, ihit}, 32'h0);
      imemaddr = 32'h100;
      settle();
      chk("ar_100_miss", {31'b0, ihit}, 32'h0);
      imemREN = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter FRAMES, default 16, number of direct-mapped one-word frames (power of two, 2..64).
REQ-002 SHALL have port CLK  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port nRST  input  1  reset, asynchronous and active-high (1 = reset asserted).
REQ-004 SHALL have port imemREN  input  1  datapath instruction-read request.
REQ-005 SHALL have port imemaddr  input  32  datapath instruction byte address (word-aligned).
REQ-006 SHALL have port imemload  output  32  instruction returned to datapath.
REQ-007 SHALL have port ihit  output  1  imemload valid this cycle.
REQ-008 SHALL have port iflush  input  1  invalidate all frames.
REQ-009 SHALL have port iREN  output  1  instruction-read request toward memory controller.
REQ-010 SHALL have port iaddr  output  32  word address of miss toward memory controller.
REQ-011 SHALL have port iload  input  32  instruction data from memory controller.
REQ-012 SHALL have port iwait  input  1  memory controller busy; 0 = iload valid, access completes this cycle.

Function
REQ-013 SHALL split imemaddr as: bits [1:0] ignored, index = next log2(FRAMES) bits, tag = remaining upper bits.
REQ-014 SHALL hold per frame: valid bit, tag, 32-bit data; storage in flops, no reset of tag/data required.
REQ-015 SHALL implement a two-state FSM: IDLE, FETCH.
REQ-016 IDLE: ihit = imemREN & valid[index] & (tag match), combinational, same cycle (zero-latency hit).
REQ-017 IDLE: imemload = frame data when ihit=1, else 32'h0.
REQ-018 IDLE: imemREN=1 and no hit -> latch {imemaddr[31:2],2'b00} as miss address, next state FETCH.
REQ-019 IDLE: imemREN=0 -> ihit=0, remain IDLE, iREN=0.
REQ-020 FETCH: iREN=1, iaddr = latched miss address (stable for whole FETCH), ihit=0, imemload=0.
REQ-021 FETCH: iwait=1 -> remain FETCH, no frame write.
REQ-022 FETCH: iwait=0 -> at edge write iload, latched tag, valid=1 into latched index; next state IDLE.
REQ-023 Miss latency: hit re-evaluated in IDLE the cycle after iwait=0; miss with memory latency N wait cycles yields ihit N+2 cycles after miss detection.
REQ-024 imemaddr changing during FETCH SHALL NOT alter the fill; IDLE re-lookup uses the then-current imemaddr.
REQ-025 iREN, iaddr SHALL be 0 in IDLE.
REQ-026 iflush=1 at edge SHALL clear all valid bits; ihit forced 0 in the iflush cycle.
REQ-027 iflush=1 in FETCH SHALL abort: no frame write (even if iwait=0 same cycle), next state IDLE.
REQ-028 Conflict fill: fill to an index holding a different valid tag SHALL overwrite it.

Reset
REQ-029 nRST=1 SHALL immediately force state IDLE, all valid bits 0, latched miss address 0.
REQ-030 During reset outputs SHALL be: ihit=0, imemload=0, iREN=0, iaddr=0.
REQ-031 Reset asserted mid-FETCH SHALL drop iREN in the same cycle, without a clock edge; no frame written.
REQ-032 After nRST deasserts, first imemREN to any address SHALL miss.

Verification
REQ-033 Cold miss: reset, imemREN=1, imemaddr=0x00000040, iwait=1 for 3 cycles then 0 with iload=0x8C010004 -> iREN=1, iaddr=0x40 for 4 cycles; next cycle ihit=1, imemload=0x8C010004.
REQ-034 Hit: repeat read of 0x40 -> ihit=1 same cycle, iREN stays 0.
REQ-035 Conflict: with FRAMES=16 read 0x40 then 0x440 (same index 0) then 0x40 -> three misses, each iaddr matching request.
REQ-036 Address change in FETCH: miss on 0x80, switch imemaddr to 0x84 before iwait=0 -> iaddr stays 0x80; frame 0 tag of 0x80 filled; then 0x84 misses.
REQ-037 Flush: fill 0x40, pulse iflush -> next read of 0x40 misses; iflush with iwait=0 in FETCH -> no fill, state IDLE.
REQ-038 Async reset mid-FETCH: assert nRST between edges -> iREN=0 immediately; after release read of prior address misses.
